// File: rtl/l1_port_hakemi_pkg.sv
// ---------------------------------------------------------------------------
// l1_port_hakemi_pkg
// Shared constants and types for the L1 port arbiter.
//   ADRES_BIT / VERI_BIT / VERI_BYTE : bus widths
//   KUYRUK_DERINLIK                  : default owner-queue depth
//   HAKEM_R0 / HAKEM_R1              : requester ID encodings
// ---------------------------------------------------------------------------
package l1_port_hakemi_pkg;

  localparam int ADRES_BIT       = 32;
  localparam int VERI_BIT        = 32;
  localparam int VERI_BYTE       = VERI_BIT / 8;
  localparam int KUYRUK_DERINLIK = 2;

  // One bit is enough to name either requester.
  typedef logic hakem_id_t;

  localparam hakem_id_t HAKEM_R0 = 1'b0;
  localparam hakem_id_t HAKEM_R1 = 1'b1;

endpackage

// File: rtl/l1_port_hakemi_if.sv
// ---------------------------------------------------------------------------
// l1_port_hakemi_if
// Request / read-data handshake bundle, identical for each requester and for
// the L1 side.
//   master : issues istek_* and veri_hazir, receives istek_hazir, veri,
//            veri_gecerli
//   slave  : the opposite direction
// ---------------------------------------------------------------------------
interface l1_port_hakemi_if
  import l1_port_hakemi_pkg::*;
();

  logic [ADRES_BIT-1:0] istek_adres;
  logic                 istek_gecerli;
  logic                 istek_onbellekleme;
  logic                 istek_yaz;
  logic [VERI_BIT-1:0]  istek_veri;
  logic [VERI_BYTE-1:0] istek_maske;
  logic                 istek_hazir;
  logic [VERI_BIT-1:0]  veri;
  logic                 veri_gecerli;
  logic                 veri_hazir;

  modport master (
    output istek_adres, istek_gecerli, istek_onbellekleme, istek_yaz,
           istek_veri, istek_maske, veri_hazir,
    input  istek_hazir, veri, veri_gecerli
  );

  modport slave (
    input  istek_adres, istek_gecerli, istek_onbellekleme, istek_yaz,
           istek_veri, istek_maske, veri_hazir,
    output istek_hazir, veri, veri_gecerli
  );

endinterface

// File: rtl/l1_port_hakemi_sahip_kuyrugu.sv
// ---------------------------------------------------------------------------
// sahip_kuyrugu
// 1-bit wide synchronous FIFO holding the owner ID of each outstanding read.
// The head entry is visible combinationally on veri_o (show-ahead).
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   yaz_i, veri_i : push request and pushed ID (ignored while full)
//   oku_i         : pop request (ignored while empty)
//   veri_o        : head ID
//   bos_o, dolu_o : empty / full flags
// ---------------------------------------------------------------------------
module sahip_kuyrugu
  import l1_port_hakemi_pkg::*;
#(
  parameter int DERINLIK = 2
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  input  logic      yaz_i,
  input  hakem_id_t veri_i,
  input  logic      oku_i,
  output hakem_id_t veri_o,
  output logic      bos_o,
  output logic      dolu_o
);

  localparam int PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;

  hakem_id_t     mem_q [DERINLIK];
  hakem_id_t     mem_d [DERINLIK];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   sayi_q, sayi_d;
  logic          yaz_ok, oku_ok;

  assign bos_o  = (sayi_q == '0);
  assign dolu_o = (sayi_q == (PW+1)'(DERINLIK));
  assign veri_o = mem_q[rd_ptr_q];

  // Full blocks a push even if a pop happens in the same cycle.
  assign yaz_ok = yaz_i & ~dolu_o;
  assign oku_ok = oku_i & ~bos_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sayi_d   = sayi_q;
    if (yaz_ok) begin
      mem_d[wr_ptr_q] = veri_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);  // power-of-two depth wraps naturally
    end
    if (oku_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({yaz_ok, oku_ok})
      2'b10:   sayi_d = sayi_q + (PW+1)'(1);
      2'b01:   sayi_d = sayi_q - (PW+1)'(1);
      default: sayi_d = sayi_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DERINLIK; i++) mem_q[i] <= HAKEM_R0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sayi_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sayi_q   <= sayi_d;
    end
  end

endmodule

// File: rtl/l1_port_hakemi.sv
// ---------------------------------------------------------------------------
// l1_port_hakemi
// Two-requester arbiter in front of the single L1 data-controller port.
// Requests pass through combinationally; a grant that L1 does not accept is
// locked until accepted. Each accepted read records its owner in a queue so
// that returning L1 data is steered back in issue order.
//   clk_i, rstn_i  : clock, asynchronous active-low reset
//   r0, r1         : requester handshakes (r0 = data bus unit)
//   port           : L1 side handshake
//   kuyruk_dolu_o  : owner queue full
// Build option L1_HAKEM_SABIT_ONCELIK_EN: fixed priority (r0 wins when not
// locked) instead of round robin.
// ---------------------------------------------------------------------------
module l1_port_hakemi
  import l1_port_hakemi_pkg::*;
#(
  parameter int KUYRUK_DERINLIK = l1_port_hakemi_pkg::KUYRUK_DERINLIK
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  l1_port_hakemi_if.slave  r0,
  l1_port_hakemi_if.slave  r1,
  l1_port_hakemi_if.master port,
  output logic             kuyruk_dolu_o
);

  logic      kilit_q, kilit_d;
  hakem_id_t sahip_q, sahip_d;
  hakem_id_t oncelik;
  hakem_id_t grant;
  logic      uygun0, uygun1;
  logic      sec_gecerli;
  logic      kabul;
  logic      push, pop;
  hakem_id_t bas;
  logic      bos, dolu;

  // A read may only be presented while the queue has room; writes always can.
  assign uygun0 = r0.istek_gecerli & (r0.istek_yaz | ~dolu);
  assign uygun1 = r1.istek_gecerli & (r1.istek_yaz | ~dolu);

  always_comb begin
    grant = HAKEM_R0;
    if (kilit_q)              grant = sahip_q;
    else if (uygun0 & uygun1) grant = oncelik;
    else if (uygun1)          grant = HAKEM_R1;
    else                      grant = HAKEM_R0;
  end

  assign sec_gecerli = (grant == HAKEM_R1) ? uygun1 : uygun0;
  assign kabul       = sec_gecerli & port.istek_hazir;

  // Request path: straight mux of the granted requester.
  assign port.istek_gecerli      = sec_gecerli;
  assign port.istek_adres        = (grant == HAKEM_R1) ? r1.istek_adres        : r0.istek_adres;
  assign port.istek_onbellekleme = (grant == HAKEM_R1) ? r1.istek_onbellekleme : r0.istek_onbellekleme;
  assign port.istek_yaz          = (grant == HAKEM_R1) ? r1.istek_yaz          : r0.istek_yaz;
  assign port.istek_veri         = (grant == HAKEM_R1) ? r1.istek_veri         : r0.istek_veri;
  assign port.istek_maske        = (grant == HAKEM_R1) ? r1.istek_maske        : r0.istek_maske;

  assign r0.istek_hazir = kabul & (grant == HAKEM_R0);
  assign r1.istek_hazir = kabul & (grant == HAKEM_R1);

  // Lock holds a presented-but-unaccepted grant so it is never retracted.
  always_comb begin
    kilit_d = kilit_q;
    sahip_d = sahip_q;
    if (sec_gecerli) begin
      if (port.istek_hazir) begin
        kilit_d = 1'b0;
      end else begin
        kilit_d = 1'b1;
        sahip_d = grant;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      kilit_q <= 1'b0;
      sahip_q <= HAKEM_R0;
    end else begin
      kilit_q <= kilit_d;
      sahip_q <= sahip_d;
    end
  end

`ifdef L1_HAKEM_SABIT_ONCELIK_EN
  assign oncelik = HAKEM_R0;
`else
  hakem_id_t oncelik_q, oncelik_d;

  // After each accepted request the other requester gets priority.
  always_comb begin
    oncelik_d = oncelik_q;
    if (kabul) oncelik_d = ~grant;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) oncelik_q <= HAKEM_R0;
    else         oncelik_q <= oncelik_d;
  end

  assign oncelik = oncelik_q;
`endif

  // Owner bookkeeping: only accepted reads enter the queue.
  assign push = kabul & ~port.istek_yaz;
  assign pop  = port.veri_gecerli & port.veri_hazir;

  sahip_kuyrugu #(
    .DERINLIK (KUYRUK_DERINLIK)
  ) u_sahip_kuyrugu (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .yaz_i  (push),
    .veri_i (grant),
    .oku_i  (pop),
    .veri_o (bas),
    .bos_o  (bos),
    .dolu_o (dolu)
  );

  assign kuyruk_dolu_o = dolu;

  // Response path: only the head owner sees data; nothing is acknowledged
  // while no read is outstanding.
  assign port.veri_hazir = ~bos & ((bas == HAKEM_R1) ? r1.veri_hazir : r0.veri_hazir);

  assign r0.veri_gecerli = port.veri_gecerli & ~bos & (bas == HAKEM_R0);
  assign r1.veri_gecerli = port.veri_gecerli & ~bos & (bas == HAKEM_R1);
  assign r0.veri         = (~bos & (bas == HAKEM_R0)) ? port.veri : '0;
  assign r1.veri         = (~bos & (bas == HAKEM_R1)) ? port.veri : '0;

endmodule
